// File: rtl/norm_shift.sv
// norm_shift: iterative normalizer. Finds the left shift that normalizes an
// operand, either counting leading zeros (unsigned) or redundant sign bits
// (signed), with one binary-search step per clock.
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   valid_i / ready_o    request handshake (ready_o only while idle)
//   data_i, signed_i     operand and mode (0: leading zeros, 1: sign bits)
//   valid_o / ready_i    result handshake (valid_o only while done)
//   data_o               normalized operand (left-shifted, zero-filled)
//   shamt_o              applied left shift amount
//   zero_o               operand was all zeros
//
// Optional build macro NORM_SHIFT_BYPASS_EN: zero or already-normalized
// operands skip the search and complete one edge after accept.
module norm_shift #(
  parameter int unsigned WIDTH_P       = 32,
  parameter int unsigned SHAMT_WIDTH_P = $clog2(WIDTH_P)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     valid_i,
  output logic                     ready_o,
  input  logic [WIDTH_P-1:0]       data_i,
  input  logic                     signed_i,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic [WIDTH_P-1:0]       data_o,
  output logic [SHAMT_WIDTH_P-1:0] shamt_o,
  output logic                     zero_o
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  localparam logic [WIDTH_P-1:0] ONES = '1;

  state_e                   state_q, state_d;
  logic [WIDTH_P-1:0]       data_q, data_d;
  logic [SHAMT_WIDTH_P-1:0] shamt_q, shamt_d;
  logic [SHAMT_WIDTH_P-1:0] k_q, k_d;
  logic                     zero_q, zero_d;
  logic                     signed_q, signed_d;
  logic                     valid_q, valid_d;
  logic                     ready_q, ready_d;

  logic [SHAMT_WIDTH_P-1:0] step;
  logic [WIDTH_P-1:0]       mask_u, mask_s;
  logic                     hit;
  logic                     in_zero, in_norm;

  always_comb begin
    // Current step size 2^k; masks select the top 2^k (unsigned) or
    // 2^k+1 (signed) bits of the working value.
    step   = SHAMT_WIDTH_P'(1) << k_q;
    mask_u = ~(ONES >> step);
    mask_s = ~(ONES >> (step + SHAMT_WIDTH_P'(1)));
    if (signed_q) begin
      hit = ((data_q & mask_s) == '0) || ((data_q & mask_s) == mask_s);
    end else begin
      hit = ((data_q & mask_u) == '0);
    end

    in_zero = (data_i == '0);
    in_norm = signed_i ? (data_i[WIDTH_P-1] ^ data_i[WIDTH_P-2])
                       : data_i[WIDTH_P-1];

    state_d  = state_q;
    data_d   = data_q;
    shamt_d  = shamt_q;
    k_d      = k_q;
    zero_d   = zero_q;
    signed_d = signed_q;
    valid_d  = valid_q;
    ready_d  = ready_q;

    unique case (state_q)
      IDLE: begin
        if (valid_i) begin
          data_d   = data_i;
          signed_d = signed_i;
          shamt_d  = '0;
          zero_d   = in_zero;
          k_d      = SHAMT_WIDTH_P'(SHAMT_WIDTH_P - 1);
          state_d  = BUSY;
          ready_d  = 1'b0;
`ifdef NORM_SHIFT_BYPASS_EN
          // Final result is known at accept: zero shifts fully, a
          // normalized operand does not shift at all.
          if (in_zero) begin
            data_d  = '0;
            shamt_d = SHAMT_WIDTH_P'(WIDTH_P - 1);
            k_d     = '0;
            state_d = DONE;
            valid_d = 1'b1;
          end else if (in_norm) begin
            k_d     = '0;
            state_d = DONE;
            valid_d = 1'b1;
          end
`else
          if (in_norm) begin
            // No early exit in this build; the search reaches the same result.
            state_d = BUSY;
          end
`endif
        end
      end
      BUSY: begin
        if (hit) begin
          data_d  = data_q << step;
          shamt_d = shamt_q + step;
        end
        if (k_q == '0) begin
          state_d = DONE;
          valid_d = 1'b1;
        end else begin
          k_d = k_q - SHAMT_WIDTH_P'(1);
        end
      end
      DONE: begin
        if (ready_i) begin
          state_d = IDLE;
          valid_d = 1'b0;
          ready_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      data_q   <= '0;
      shamt_q  <= '0;
      k_q      <= '0;
      zero_q   <= 1'b0;
      signed_q <= 1'b0;
      valid_q  <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      shamt_q  <= shamt_d;
      k_q      <= k_d;
      zero_q   <= zero_d;
      signed_q <= signed_d;
      valid_q  <= valid_d;
      ready_q  <= ready_d;
    end
  end

  assign ready_o = ready_q;
  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign shamt_o = shamt_q;
  assign zero_o  = zero_q;

endmodule

// File: tb/tb_norm_shift.sv
// Scoreboard bench for norm_shift (WIDTH_P = 32): expected results are
// queued at accept and compared when the result handshake completes.
module tb_norm_shift;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        valid_i;
  logic        ready_o;
  logic [31:0] data_i;
  logic        signed_i;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] data_o;
  logic [4:0]  shamt_o;
  logic        zero_o;

  norm_shift #(.WIDTH_P(32), .SHAMT_WIDTH_P(5)) dut (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .data_i   (data_i),
    .signed_i (signed_i),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .data_o   (data_o),
    .shamt_o  (shamt_o),
    .zero_o   (zero_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] d;
    logic [31:0] sh;
    logic        z;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference: count leading zeros / redundant sign bits directly.
  function automatic exp_t model(input logic [31:0] d, input logic s);
    exp_t e;
    int   n = 0;
    if (!s) begin
      while (n < 31 && d[31-n] == 1'b0) n++;
    end else begin
      while (n < 31 && d[30-n] == d[31]) n++;
    end
    e.d   = d << n;
    e.sh  = 32'(n);
    e.z   = (d == 32'h0);
    e.lat = 5;
`ifdef NORM_SHIFT_BYPASS_EN
    if (d == 32'h0 || (s ? (d[31] ^ d[30]) : d[31])) e.lat = 1;
`endif
    e.acc = 0;
    return e;
  endfunction

  // Monitor: latency at first valid, hold stability, result at handshake.
  logic        seen = 1'b0;
  logic        hs_prev = 1'b0;
  logic [31:0] snap_d;
  logic [31:0] snap_sh;
  always @(negedge clk_i) begin
    if (!rst_ni) begin
      seen    = 1'b0;
      hs_prev = 1'b0;
    end else if (hs_prev) begin
      check("valid_drop", 32'(valid_o), 32'h0);
      hs_prev = 1'b0;
    end else if (valid_o) begin
      if (sb.size() == 0) begin
        check("spurious_valid", 32'(valid_o), 32'h0);
      end else begin
        if (!seen) begin
          seen    = 1'b1;
          snap_d  = data_o;
          snap_sh = 32'(shamt_o);
          check("latency", 32'(cyc - sb[0].acc), 32'(sb[0].lat));
        end else begin
          check("hold_data", data_o, snap_d);
          check("hold_shamt", 32'(shamt_o), snap_sh);
        end
        if (ready_i) begin
          exp_t e;
          e = sb.pop_front();
          check("data", data_o, e.d);
          check("shamt", 32'(shamt_o), e.sh);
          check("zero", 32'(zero_o), 32'(e.z));
          seen    = 1'b0;
          hs_prev = 1'b1;
        end
      end
    end
  end

  // Called #1 after a rising edge; returns #1 after the accepting edge.
  task automatic send(input logic [31:0] d, input logic s);
    int   w = 0;
    exp_t e;
    valid_i  = 1'b1;
    data_i   = d;
    signed_i = s;
    while (!ready_o && w < 60) begin
      @(posedge clk_i); #1;
      w++;
    end
    if (!ready_o) begin
      check("ready_timeout", 32'(ready_o), 32'h1);
      valid_i = 1'b0;
      return;
    end
    @(posedge clk_i); #1;
    e     = model(d, s);
    e.acc = cyc;
    sb.push_back(e);
    // Disturb inputs after accept; the result must not change.
    valid_i  = 1'b0;
    data_i   = $urandom;
    signed_i = ~s;
  endtask

  task automatic wait_done();
    int w = 0;
    while (sb.size() != 0 && w < 60) begin
      @(posedge clk_i); #1;
      w++;
    end
    if (sb.size() != 0) check("done_timeout", 32'(sb.size()), 32'h0);
    @(posedge clk_i); #1;
  endtask

  logic [31:0] dir_d [10] = '{32'h00000001, 32'hFFFF8000, 32'h00000001, 32'h00000000,
                              32'hFFFFFFFF, 32'h00000000, 32'h80000000, 32'h40000000,
                              32'hC0000000, 32'h80000000};
  logic        dir_s [10] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

  initial begin
    rst_ni   = 1'b0;
    valid_i  = 1'b1;
    data_i   = 32'h00000001;
    signed_i = 1'b0;
    ready_i  = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_ready", 32'(ready_o), 32'h1);
    check("rst_valid", 32'(valid_o), 32'h0);
    check("rst_data", data_o, 32'h0);
    check("rst_shamt", 32'(shamt_o), 32'h0);
    check("rst_zero", 32'(zero_o), 32'h0);
    rst_ni  = 1'b1;
    valid_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    check("idle_ready", 32'(ready_o), 32'h1);

    for (int i = 0; i < 10; i++) begin
      send(dir_d[i], dir_s[i]);
      wait_done();
    end

    for (int i = 0; i < 20; i++) begin
      logic [31:0] d;
      logic        s;
      d = $urandom >> $urandom_range(0, 31);
      s = 1'($urandom_range(0, 1));
      if (s && $urandom_range(0, 1) == 1) d = ~d;
      send(d, s);
      wait_done();
    end

    // Result held under backpressure while a new request waits.
    ready_i = 1'b0;
    send(32'h00000100, 1'b0);
    begin
      int w = 0;
      while (!valid_o && w < 60) begin
        @(posedge clk_i); #1;
        w++;
      end
      if (!valid_o) check("hold_timeout", 32'(valid_o), 32'h1);
    end
    valid_i  = 1'b1;
    data_i   = 32'h0000F000;
    signed_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk_i); #1;
      check("hold_ready", 32'(ready_o), 32'h0);
    end
    ready_i = 1'b1;
    send(32'h0000F000, 1'b0);
    wait_done();

    // Reset in the third busy cycle discards the pending result.
    send(32'h12345678, 1'b0);
    @(posedge clk_i);
    @(posedge clk_i);
    #2;
    rst_ni = 1'b0;
    sb.delete();
    #2;
    check("abort_valid", 32'(valid_o), 32'h0);
    check("abort_ready", 32'(ready_o), 32'h1);
    check("abort_data", data_o, 32'h0);
    check("abort_shamt", 32'(shamt_o), 32'h0);
    check("abort_zero", 32'(zero_o), 32'h0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    repeat (8) @(posedge clk_i);
    #1;
    send(32'h00F00000, 1'b0);
    wait_done();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/norm_shift.md
NORM_SHIFT -- requirements
Module: norm_shift

Interface
REQ-001 SHALL have parameter WIDTH_P, default 32, data width in bits (power of two, >= 4).
REQ-002 SHALL have parameter SHAMT_WIDTH_P, default $clog2(WIDTH_P), width of the shift-amount result.
REQ-003 clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 valid_i  input  1  request valid.
REQ-006 ready_o  output  1  block can accept a request.
REQ-007 data_i  input  WIDTH_P  operand to normalize.
REQ-008 signed_i  input  1  0: count leading zeros; 1: count redundant sign bits.
REQ-009 valid_o  output  1  result valid.
REQ-010 ready_i  input  1  downstream accepts result.
REQ-011 data_o  output  WIDTH_P  normalized operand (left-shifted, zero-filled).
REQ-012 shamt_o  output  SHAMT_WIDTH_P  left shift amount applied; inverse of a logical-left shift by shamt_o.
REQ-013 zero_o  output  1  operand was all zeros.

Function
REQ-014 States SHALL be IDLE, BUSY, DONE; ready_o = 1 only in IDLE; valid_o = 1 only in DONE.
REQ-015 Accept SHALL occur on an edge with valid_i & ready_o: capture data_i, signed_i; clear shamt accumulator; set step k = SHAMT_WIDTH_P-1; go to BUSY.
REQ-016 Each BUSY edge SHALL do one binary-search step: unsigned -- if top 2^k bits all 0; signed -- if top 2^k+1 bits all equal; then shift working value left by 2^k and add 2^k to shamt; then decrement k.
REQ-017 After the k = 0 step, BUSY SHALL go to DONE; valid_o rises exactly SHAMT_WIDTH_P edges after the accepting edge.
REQ-018 In DONE, data_o, shamt_o, zero_o SHALL hold stable until valid_o & ready_i; on that edge go to IDLE.
REQ-019 No overlap: a new request SHALL not be accepted in the DONE-to-IDLE edge; throughput one result per SHAMT_WIDTH_P+2 cycles minimum.
REQ-020 valid_i while not in IDLE SHALL be ignored; data_i, signed_i changes after accept SHALL not affect the result.
REQ-021 All-zero operand SHALL give shamt_o = WIDTH_P-1, data_o = 0, zero_o = 1 (both modes).
REQ-022 Signed all-ones operand SHALL give shamt_o = WIDTH_P-1, data_o = 1 followed by zeros, zero_o = 0.
REQ-023 Already-normalized operand (unsigned MSB = 1; signed bit WIDTH_P-1 != bit WIDTH_P-2) SHALL give shamt_o = 0, data_o = data_i.
REQ-024 Outputs data_o, shamt_o, zero_o SHALL be registered; value outside DONE is don't-care but SHALL not be X after reset.

Reset
REQ-025 rst_ni low SHALL immediately force IDLE, valid_o = 0, data_o = 0, shamt_o = 0, zero_o = 0, accumulator and step counter cleared.
REQ-026 ready_o SHALL read 1 while rst_ni low; no request SHALL be accepted until the first edge with rst_ni high.
REQ-027 Reset asserted in BUSY or DONE SHALL abort the operation; the pending result is discarded, never presented.

Configuration
REQ-028 Macro NORM_SHIFT_BYPASS_EN defined: an accepted operand that is zero or already normalized (REQ-021/023 conditions at accept) SHALL go directly to DONE with final result; valid_o rises 1 edge after accept.
REQ-029 Macro NORM_SHIFT_BYPASS_EN undefined: latency SHALL always be SHAMT_WIDTH_P edges; results identical in both builds.

Verification (WIDTH_P = 32)
REQ-030 Unsigned 0x00000001, ready_i = 1 -> data_o 0x80000000, shamt_o 31, zero_o 0, valid_o 5 edges after accept, 1 cycle high.
REQ-031 Signed 0xFFFF8000 -> data_o 0x80000000, shamt_o 16; signed 0x00000001 -> data_o 0x40000000, shamt_o 30.
REQ-032 Unsigned 0x00000000 -> data_o 0, shamt_o 31, zero_o 1; signed 0xFFFFFFFF -> data_o 0x80000000, shamt_o 31, zero_o 0.
REQ-033 Result held with ready_i = 0 for 10 cycles, valid_i = 1 with new data throughout -> outputs stable, ready_o 0, new data accepted only after handshake + return to IDLE.
REQ-034 rst_ni pulsed low on 3rd BUSY cycle -> valid_o never rises for that request, all outputs 0, ready_o 1; next request 0x00F00000 unsigned -> shamt_o 8, data_o 0xF0000000.
REQ-035 Unsigned 0x80000000: with NORM_SHIFT_BYPASS_EN -> valid_o 1 edge after accept, shamt_o 0; without -> 5 edges, same result.
